// File: rtl/rsa_uart_sequencer_if.sv
// Avalon-MM link between the RSA sequencer (master) and the UART register
// file (slave).
interface rsa_uart_sequencer_if;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/rsa_uart_sequencer.sv
// Drives the RSA256 core from a UART byte stream: loads N, d and a ciphertext
// block, starts the core and streams the plaintext back out over the UART.
module rsa_uart_sequencer #(
  parameter int KEY_BYTES   = 32,
  parameter int OUT_BYTES   = 31,
  parameter int RX_ADDR     = 0,
  parameter int TX_ADDR     = 4,
  parameter int STATUS_ADDR = 8,
  parameter int RRDY_BIT    = 7,
  parameter int TRDY_BIT    = 6
) (
  input  logic                     avm_clk,
  input  logic                     avm_rst,
  rsa_uart_sequencer_if.master     avm,
  output logic                     rsa_start,
  output logic [8*KEY_BYTES-1:0]   rsa_n,
  output logic [8*KEY_BYTES-1:0]   rsa_d,
  output logic [8*KEY_BYTES-1:0]   rsa_a,
  input  logic [8*KEY_BYTES-1:0]   rsa_result,
  input  logic                     rsa_finished,
  output logic                     led_idle
);

  localparam int W     = 8 * KEY_BYTES;
  localparam int TXW   = 8 * OUT_BYTES;
  localparam int CNT_W = $clog2(((KEY_BYTES > OUT_BYTES) ? KEY_BYTES : OUT_BYTES) + 1);

  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BYTES - 1);
  localparam logic [4:0]       A_RX     = 5'(RX_ADDR);
  localparam logic [4:0]       A_TX     = 5'(TX_ADDR);
  localparam logic [4:0]       A_STATUS = 5'(STATUS_ADDR);

  typedef enum logic [2:0] {
    S_POLL_RX,
    S_READ_RX,
    S_CALC,
    S_POLL_TX,
    S_WRITE_TX
  } state_t;

  typedef enum logic [1:0] {
    PH_N,
    PH_D,
    PH_A
  } phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [W-1:0]     key_n_q, key_n_d;
  logic [W-1:0]     key_d_q, key_d_d;
  logic [W-1:0]     blk_a_q, blk_a_d;
  logic [W-1:0]     tx_shift_q, tx_shift_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [4:0]       addr_q, addr_d;
  logic             start_q, start_d;
  logic             led_q, led_d;

  logic             rd_done;
  logic             wr_done;
  logic [7:0]       rx_byte;

  assign rd_done = rd_q && !avm.avm_waitrequest;
  assign wr_done = wr_q && !avm.avm_waitrequest;
  assign rx_byte = avm.avm_readdata[7:0];

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    byte_cnt_d = byte_cnt_q;
    key_n_d    = key_n_q;
    key_d_d    = key_d_q;
    blk_a_d    = blk_a_q;
    tx_shift_d = tx_shift_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    start_d    = 1'b0;

    case (state_q)
      S_POLL_RX: begin
        if (rd_done && avm.avm_readdata[RRDY_BIT]) begin
          state_d = S_READ_RX;
          addr_d  = A_RX;
        end
      end

      S_READ_RX: begin
        if (rd_done) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          case (phase_q)
            PH_N:    key_n_d = {key_n_q[W-9:0], rx_byte};
            PH_D:    key_d_d = {key_d_q[W-9:0], rx_byte};
            default: blk_a_d = {blk_a_q[W-9:0], rx_byte};
          endcase
          state_d = S_POLL_RX;
          addr_d  = A_STATUS;
          if (byte_cnt_q == KEY_LAST) begin
            byte_cnt_d = '0;
            case (phase_q)
              PH_N: phase_d = PH_D;
              PH_D: phase_d = PH_A;
              default: begin
                // Ciphertext complete: kick the core and release the bus.
                start_d = 1'b1;
                state_d = S_CALC;
                rd_d    = 1'b0;
              end
            endcase
          end
        end
      end

      S_CALC: begin
        // A finish strobe coincident with our own start pulse is stale.
        if (rsa_finished && !start_q) begin
          tx_shift_d = rsa_result;
          state_d    = S_POLL_TX;
          rd_d       = 1'b1;
          addr_d     = A_STATUS;
        end
      end

      S_POLL_TX: begin
        if (rd_done && avm.avm_readdata[TRDY_BIT]) begin
          state_d = S_WRITE_TX;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          addr_d  = A_TX;
        end
      end

      S_WRITE_TX: begin
        if (wr_done) begin
          tx_shift_d = tx_shift_q << 8;
          wr_d       = 1'b0;
          rd_d       = 1'b1;
          addr_d     = A_STATUS;
          if (byte_cnt_q == OUT_LAST) begin
            // Key stays loaded; only the next ciphertext block is awaited.
            byte_cnt_d = '0;
            phase_d    = PH_A;
            state_d    = S_POLL_RX;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = S_POLL_TX;
          end
        end
      end

      default: begin
        state_d = S_POLL_RX;
        rd_d    = 1'b1;
        wr_d    = 1'b0;
        addr_d  = A_STATUS;
      end
    endcase

    led_d = ((state_d == S_POLL_RX) || (state_d == S_READ_RX)) &&
            (phase_d == PH_A) && (byte_cnt_d == '0);
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q    <= S_POLL_RX;
      phase_q    <= PH_N;
      byte_cnt_q <= '0;
      key_n_q    <= '0;
      key_d_q    <= '0;
      blk_a_q    <= '0;
      tx_shift_q <= '0;
      rd_q       <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= A_STATUS;
      start_q    <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      byte_cnt_q <= byte_cnt_d;
      key_n_q    <= key_n_d;
      key_d_q    <= key_d_d;
      blk_a_q    <= blk_a_d;
      tx_shift_q <= tx_shift_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      start_q    <= start_d;
      led_q      <= led_d;
    end
  end

  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = rd_q;
  assign avm.avm_write     = wr_q;
  assign avm.avm_writedata = {24'h0, tx_shift_q[TXW-1 -: 8]};

  assign rsa_start = start_q;
  assign rsa_n     = key_n_q;
  assign rsa_d     = key_d_q;
  assign rsa_a     = blk_a_q;
  assign led_idle  = led_q;

  // Only the low result bytes are transmitted and only the low readdata byte
  // carries UART payload.
  logic unused_ok;
  assign unused_ok = ^{avm.avm_readdata[31:8], tx_shift_q};

endmodule
